// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master round-robin bus arbiter.
// Optional watchdog build macro: BUS_ARB_TIMEOUT_EN.
package bus_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    localparam logic [DATA_W-1:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    function automatic logic other_grant(input logic grant);
        return (grant == GRANT_A) ? GRANT_B : GRANT_A;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// One CPU memory-bus channel. The master modport issues requests, the slave
// modport answers them.
interface bus_arbiter_if;
    import bus_arb_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] data_in;
    logic              write_enable;
    logic [MASK_W-1:0] write_mask;
    logic              transaction_begin;
    logic              transaction_end;

    modport master (
        output address,
        output data_out,
        output write_enable,
        output write_mask,
        output transaction_begin,
        input  data_in,
        input  transaction_end
    );

    modport slave (
        input  address,
        input  data_out,
        input  write_enable,
        input  write_mask,
        input  transaction_begin,
        output data_in,
        output transaction_end
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that did not hold the previous grant.
module rr_pick2
    import bus_arb_pkg::*;
(
    input  logic pend_a,
    input  logic pend_b,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = pend_a | pend_b;
        winner = GRANT_A;
        if (pend_a && pend_b) begin
            winner = other_grant(last_grant);
        end else if (pend_b) begin
            winner = GRANT_B;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin bus arbiter (IDLE -> ISSUE -> WAIT).
// Define BUS_ARB_TIMEOUT_EN to enable the WAIT-state watchdog and bus_error.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clock,
    input  logic          reset,
    bus_arbiter_if.slave  port_a,
    bus_arbiter_if.slave  port_b,
    bus_arbiter_if.master port_y,
    output logic          select,
    output logic          bus_error
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e state_q, state_d;
    logic       pend_a_q, pend_a_d;
    logic       pend_b_q, pend_b_d;
    logic       select_q, select_d;
    logic       last_grant_q, last_grant_d;
    logic       begin_y_q, begin_y_d;

    logic       pick_valid;
    logic       pick_winner;
    logic       timeout;
    logic       complete;
    logic       done_a;
    logic       done_b;

    rr_pick2 u_pick (
        .pend_a     (pend_a_q),
        .pend_b     (pend_b_q),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    // ISSUE always precedes WAIT, so clearing there gives count 0 in the first WAIT cycle.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == WAIT) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A real slave completion in the same cycle takes priority over the watchdog.
    assign timeout = (state_q == WAIT) && (wait_cnt_q == LAST_CNT) && !port_y.transaction_end;
`else
    assign timeout = 1'b0;
`endif

    assign bus_error = timeout;
    assign complete  = (state_q == WAIT) && (port_y.transaction_end || timeout);
    assign done_a    = complete && (select_q == GRANT_A);
    assign done_b    = complete && (select_q == GRANT_B);

    always_comb begin
        state_d      = state_q;
        select_d     = select_q;
        last_grant_d = last_grant_q;
        begin_y_d    = 1'b0;
        // Completion clears the bit even if the same master pulses begin again that cycle.
        pend_a_d     = (pend_a_q | port_a.transaction_begin) & ~done_a;
        pend_b_d     = (pend_b_q | port_b.transaction_begin) & ~done_b;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d      = ISSUE;
                    select_d     = pick_winner;
                    last_grant_d = pick_winner;
                    begin_y_d    = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (complete) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_a_q     <= 1'b0;
            pend_b_q     <= 1'b0;
            select_q     <= GRANT_A;
            last_grant_q <= GRANT_B;
            begin_y_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
            select_q     <= select_d;
            last_grant_q <= last_grant_d;
            begin_y_q    <= begin_y_d;
        end
    end

    assign select                   = select_q;
    assign port_y.transaction_begin = begin_y_q;

    assign port_y.address      = (select_q == GRANT_B) ? port_b.address    : port_a.address;
    assign port_y.data_out     = (select_q == GRANT_B) ? port_b.data_out   : port_a.data_out;
    assign port_y.write_mask   = (select_q == GRANT_B) ? port_b.write_mask : port_a.write_mask;
    assign port_y.write_enable = (state_q == IDLE) ? 1'b0 :
                                 (select_q == GRANT_B) ? port_b.write_enable : port_a.write_enable;

    assign port_a.transaction_end = done_a;
    assign port_b.transaction_end = done_b;

    assign port_a.data_in = (timeout && (select_q == GRANT_A)) ? BUS_ERR_DATA : port_y.data_in;
    assign port_b.data_in = (timeout && (select_q == GRANT_B)) ? BUS_ERR_DATA : port_y.data_in;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized run
// checked against a rule-level scheduling model.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset;
    logic select;
    logic bus_error;
    int   checks = 0;
    int   errors = 0;

    bus_arbiter_if if_a ();
    bus_arbiter_if if_b ();
    bus_arbiter_if if_y ();

    bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .port_a    (if_a),
        .port_b    (if_b),
        .port_y    (if_y),
        .select    (select),
        .bus_error (bus_error)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        if_a.transaction_begin = 1'b0;
        if_b.transaction_begin = 1'b0;
        if_y.transaction_end   = 1'b0;
        if_y.data_in           = 32'h0;
    endtask

    task automatic set_master(input int m, input logic [31:0] addr, input logic [31:0] dout,
                              input logic we, input logic [3:0] mask);
        if (m == 0) begin
            if_a.address = addr; if_a.data_out = dout; if_a.write_enable = we; if_a.write_mask = mask;
        end else begin
            if_b.address = addr; if_b.data_out = dout; if_b.write_enable = we; if_b.write_mask = mask;
        end
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        set_master(0, 32'h10, 32'h20, 1'b1, 4'h3);
        set_master(1, 32'h30, 32'h40, 1'b1, 4'h5);
        reset = 1'b1;
        if_y.transaction_end = 1'b1;
        #2;
        checks++; if (if_y.transaction_begin !== 1'b0) begin errors++; $display("FAIL reset_begin_y got %b exp 0", if_y.transaction_begin); end
        checks++; if (if_a.transaction_end !== 1'b0) begin errors++; $display("FAIL reset_end_a got %b exp 0", if_a.transaction_end); end
        checks++; if (if_b.transaction_end !== 1'b0) begin errors++; $display("FAIL reset_end_b got %b exp 0", if_b.transaction_end); end
        checks++; if (select !== 1'b0) begin errors++; $display("FAIL reset_select got %b exp 0", select); end
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_bus_error got %b exp 0", bus_error); end
        checks++; if (if_y.write_enable !== 1'b0) begin errors++; $display("FAIL reset_we_y got %b exp 0", if_y.write_enable); end
        tick();
        reset = 1'b0;
        if_y.transaction_end = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++; if (if_y.transaction_begin !== 1'b0) begin errors++; $display("FAIL reset_idle_begin k=%0d got %b exp 0", k, if_y.transaction_begin); end
            tick();
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 0) set_master(0, 32'h100, 32'h0, 1'b0, 4'hF);
            if_a.transaction_begin = (k == 0);
            if_y.transaction_end   = (k == 4);
            if_y.data_in           = (k == 4) ? 32'hCAFE0001 : 32'h0;
            @(negedge clock);
            checks++; if (if_y.transaction_begin !== (k == 2)) begin errors++; $display("FAIL single_begin_y k=%0d got %b exp %b", k, if_y.transaction_begin, (k == 2)); end
            if (k == 2) begin
                checks++; if (select !== 1'b0) begin errors++; $display("FAIL single_select got %b exp 0", select); end
                checks++; if (if_y.address !== 32'h100) begin errors++; $display("FAIL single_addr_y got %h exp 100", if_y.address); end
            end
            checks++; if (if_a.transaction_end !== (k == 4)) begin errors++; $display("FAIL single_end_a k=%0d got %b exp %b", k, if_a.transaction_end, (k == 4)); end
            checks++; if (if_b.transaction_end !== 1'b0) begin errors++; $display("FAIL single_end_b k=%0d got %b exp 0", k, if_b.transaction_end); end
            if (k == 4) begin
                checks++; if (if_a.data_in !== 32'hCAFE0001) begin errors++; $display("FAIL single_data_a got %h exp cafe0001", if_a.data_in); end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic eb, ea, ebb, es;
        apply_reset();
        for (int k = 0; k < 15; k++) begin
            tick();
            if (k == 0) begin
                set_master(0, 32'h200, 32'hA0, 1'b0, 4'h1);
                set_master(1, 32'h300, 32'hB0, 1'b1, 4'h2);
            end
            if_a.transaction_begin = (k == 0) || (k == 7);
            if_b.transaction_begin = (k == 0) || (k == 7);
            if_y.transaction_end   = (k inside {3, 6, 10, 13});
            if_y.data_in           = 32'h5000 + 32'(k);
            eb  = (k inside {2, 5, 9, 12});
            es  = (k inside {5, 12});
            ea  = (k inside {3, 10});
            ebb = (k inside {6, 13});
            @(negedge clock);
            checks++; if (if_y.transaction_begin !== eb) begin errors++; $display("FAIL simul_begin_y k=%0d got %b exp %b", k, if_y.transaction_begin, eb); end
            if (eb) begin
                checks++; if (select !== es) begin errors++; $display("FAIL simul_select k=%0d got %b exp %b", k, select, es); end
                checks++; if (if_y.address !== (es ? 32'h300 : 32'h200)) begin errors++; $display("FAIL simul_addr_y k=%0d got %h", k, if_y.address); end
                checks++; if (if_y.write_enable !== es) begin errors++; $display("FAIL simul_we_y k=%0d got %b exp %b", k, if_y.write_enable, es); end
            end
            checks++; if (if_a.transaction_end !== ea) begin errors++; $display("FAIL simul_end_a k=%0d got %b exp %b", k, if_a.transaction_end, ea); end
            checks++; if (if_b.transaction_end !== ebb) begin errors++; $display("FAIL simul_end_b k=%0d got %b exp %b", k, if_b.transaction_end, ebb); end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic eb, es, ea, ebb;
        int   nbeg;
        nbeg = 0;
        apply_reset();
        for (int k = 0; k < 14; k++) begin
            tick();
            if (k == 0) set_master(0, 32'h400, 32'h1, 1'b1, 4'hF);
            if (k == 3) set_master(1, 32'h500, 32'h2, 1'b0, 4'h0);
            if (k == 6) set_master(0, 32'h440, 32'h3, 1'b0, 4'h8);
            if_a.transaction_begin = (k == 0) || (k == 6);
            if_b.transaction_begin = (k == 3);
            if_y.transaction_end   = (k inside {5, 8, 11});
            if_y.data_in           = 32'h1000 + 32'(k);
            eb  = (k inside {2, 7, 10});
            es  = (k == 7);
            ea  = (k inside {5, 11});
            ebb = (k == 8);
            @(negedge clock);
            if (if_y.transaction_begin === 1'b1) nbeg++;
            checks++; if (if_y.transaction_begin !== eb) begin errors++; $display("FAIL b2b_begin_y k=%0d got %b exp %b", k, if_y.transaction_begin, eb); end
            if (eb) begin
                checks++; if (select !== es) begin errors++; $display("FAIL b2b_select k=%0d got %b exp %b", k, select, es); end
            end
            if (k == 10) begin
                checks++; if (if_y.address !== 32'h440) begin errors++; $display("FAIL b2b_addr_y got %h exp 440", if_y.address); end
            end
            checks++; if (if_a.transaction_end !== ea) begin errors++; $display("FAIL b2b_end_a k=%0d got %b exp %b", k, if_a.transaction_end, ea); end
            checks++; if (if_b.transaction_end !== ebb) begin errors++; $display("FAIL b2b_end_b k=%0d got %b exp %b", k, if_b.transaction_end, ebb); end
            if (k == 8) begin
                checks++; if (if_b.data_in !== 32'h1008) begin errors++; $display("FAIL b2b_data_b got %h exp 1008", if_b.data_in); end
            end
        end
        checks++; if (nbeg !== 3) begin errors++; $display("FAIL b2b_issue_count got %0d exp 3", nbeg); end
        idle_inputs();
    endtask

    task automatic test_spurious();
        apply_reset();
        for (int k = 0; k < 13; k++) begin
            tick();
            if (k == 2) set_master(0, 32'h800, 32'h9, 1'b0, 4'h1);
            if_a.transaction_begin = (k == 2) || (k == 5);
            if_y.transaction_end   = (k inside {0, 4, 7});
            if_y.data_in           = 32'h77;
            @(negedge clock);
            checks++; if (if_y.transaction_begin !== (k == 4)) begin errors++; $display("FAIL spur_begin_y k=%0d got %b exp %b", k, if_y.transaction_begin, (k == 4)); end
            checks++; if (if_a.transaction_end !== (k == 7)) begin errors++; $display("FAIL spur_end_a k=%0d got %b exp %b", k, if_a.transaction_end, (k == 7)); end
            checks++; if (if_b.transaction_end !== 1'b0) begin errors++; $display("FAIL spur_end_b k=%0d got %b exp 0", k, if_b.transaction_end); end
        end
        idle_inputs();
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        for (int k = 0; k < 29; k++) begin
            tick();
            if (k == 0) set_master(0, 32'h900, 32'h0, 1'b0, 4'hF);
            if_a.transaction_begin = (k == 0) || (k == 16);
            if_y.transaction_end   = (k == 13) || (k == 26);
            if_y.data_in           = (k == 26) ? 32'h0BADF00D : 32'h12345678;
            @(negedge clock);
            checks++; if (if_y.transaction_begin !== (k == 2 || k == 18)) begin errors++; $display("FAIL to_begin_y k=%0d got %b", k, if_y.transaction_begin); end
            checks++; if (if_a.transaction_end !== (k == 10 || k == 26)) begin errors++; $display("FAIL to_end_a k=%0d got %b", k, if_a.transaction_end); end
            checks++; if (bus_error !== (k == 10)) begin errors++; $display("FAIL to_bus_error k=%0d got %b exp %b", k, bus_error, (k == 10)); end
            if (k == 10) begin
                checks++; if (if_a.data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL to_data_a got %h exp deadbeef", if_a.data_in); end
                checks++; if (if_b.data_in !== 32'h12345678) begin errors++; $display("FAIL to_data_b got %h exp 12345678", if_b.data_in); end
            end
            if (k == 26) begin
                checks++; if (if_a.data_in !== 32'h0BADF00D) begin errors++; $display("FAIL to_race_data_a got %h exp 0badf00d", if_a.data_in); end
            end
        end
        idle_inputs();
    endtask
`else
    task automatic test_no_timeout();
        apply_reset();
        for (int k = 0; k < 306; k++) begin
            tick();
            if (k == 0) set_master(0, 32'hA00, 32'h0, 1'b0, 4'hF);
            if_a.transaction_begin = (k == 0);
            if_y.transaction_end   = (k == 304);
            if_y.data_in           = 32'h31;
            @(negedge clock);
            checks++; if (if_a.transaction_end !== (k == 304)) begin errors++; $display("FAIL noto_end_a k=%0d got %b", k, if_a.transaction_end); end
            checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL noto_bus_error k=%0d got %b exp 0", k, bus_error); end
        end
        idle_inputs();
    endtask
`endif

    task automatic test_reset_mid_wait();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) set_master(1, 32'h700, 32'h5, 1'b1, 4'h6);
            if (k == 3) set_master(0, 32'h600, 32'h6, 1'b1, 4'h7);
            if_b.transaction_begin = (k == 0);
            if_a.transaction_begin = (k == 3);
            @(negedge clock);
        end
        checks++; if (select !== 1'b1) begin errors++; $display("FAIL rstw_pre_select got %b exp 1", select); end
        tick();
        if_a.transaction_begin = 1'b0;
        if_y.transaction_end   = 1'b1;
        #1;
        checks++; if (if_b.transaction_end !== 1'b1) begin errors++; $display("FAIL rstw_pre_end_b got %b exp 1", if_b.transaction_end); end
        reset = 1'b1;
        #1;
        checks++; if (if_b.transaction_end !== 1'b0) begin errors++; $display("FAIL rstw_end_b got %b exp 0", if_b.transaction_end); end
        checks++; if (if_a.transaction_end !== 1'b0) begin errors++; $display("FAIL rstw_end_a got %b exp 0", if_a.transaction_end); end
        checks++; if (select !== 1'b0) begin errors++; $display("FAIL rstw_select got %b exp 0", select); end
        checks++; if (if_y.write_enable !== 1'b0) begin errors++; $display("FAIL rstw_we_y got %b exp 0", if_y.write_enable); end
        checks++; if (if_y.transaction_begin !== 1'b0) begin errors++; $display("FAIL rstw_begin_y got %b exp 0", if_y.transaction_begin); end
        tick();
        reset = 1'b0;
        @(negedge clock);
        checks++; if (if_a.transaction_end !== 1'b0 || if_b.transaction_end !== 1'b0) begin errors++; $display("FAIL rstw_late_end got %b%b exp 00", if_a.transaction_end, if_b.transaction_end); end
        tick();
        if_y.transaction_end = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checks++; if (if_y.transaction_begin !== 1'b0) begin errors++; $display("FAIL rstw_no_issue k=%0d got %b exp 0", k, if_y.transaction_begin); end
            tick();
        end
    endtask

    task automatic test_random(input int ncyc);
        logic        pend[2];
        int          since[2];
        logic [31:0] addr[2];
        logic [31:0] dout[2];
        logic        we[2];
        logic [3:0]  mask[2];
        logic        elig[2];
        logic        busy, exp_issue, exp_end, ey;
        logic [31:0] rdata;
        int          owner, last, free_at, end_at, issue_at;
        apply_reset();
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; since[m] = 0;
        end
        busy = 1'b0; owner = 0; last = 1; free_at = 0; end_at = 0; issue_at = -1;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            // A request seen two cycles ago may be granted once the bus has been idle a cycle.
            exp_issue = 1'b0;
            if (!busy && c >= free_at) begin
                elig[0] = pend[0] && (since[0] <= c - 2);
                elig[1] = pend[1] && (since[1] <= c - 2);
                if (elig[0] || elig[1]) begin
                    owner     = (elig[0] && elig[1]) ? (1 - last) : (elig[1] ? 1 : 0);
                    last      = owner;
                    busy      = 1'b1;
                    exp_issue = 1'b1;
                    issue_at  = c;
                    end_at    = c + 1 + int'($urandom_range(3));
                end
            end
            for (int m = 0; m < 2; m++) begin
                if (!pend[m]) begin
                    addr[m] = $urandom; dout[m] = $urandom;
                    we[m] = 1'($urandom_range(1)); mask[m] = 4'($urandom_range(15));
                end
                set_master(m, addr[m], dout[m], we[m], mask[m]);
            end
            if_a.transaction_begin = ($urandom_range(3) == 0);
            if_b.transaction_begin = ($urandom_range(3) == 0);
            if (if_a.transaction_begin && !pend[0]) begin pend[0] = 1'b1; since[0] = c; end
            if (if_b.transaction_begin && !pend[1]) begin pend[1] = 1'b1; since[1] = c; end
            exp_end = busy && (c == end_at);
            ey      = exp_end || ((!busy || c == issue_at) && ($urandom_range(7) == 0));
            rdata   = $urandom;
            if_y.transaction_end = ey;
            if_y.data_in         = rdata;
            @(negedge clock);
            checks++; if (if_y.transaction_begin !== exp_issue) begin errors++; $display("FAIL rnd_begin_y c=%0d got %b exp %b", c, if_y.transaction_begin, exp_issue); end
            if (exp_issue) begin
                checks++; if (select !== 1'(owner)) begin errors++; $display("FAIL rnd_select c=%0d got %b exp %0d", c, select, owner); end
                checks++; if (if_y.address !== addr[owner] || if_y.data_out !== dout[owner] ||
                              if_y.write_enable !== we[owner] || if_y.write_mask !== mask[owner]) begin
                    errors++; $display("FAIL rnd_fields c=%0d got %h/%h/%b/%h exp %h/%h/%b/%h", c, if_y.address, if_y.data_out,
                                       if_y.write_enable, if_y.write_mask, addr[owner], dout[owner], we[owner], mask[owner]);
                end
            end
            if (!busy) begin
                checks++; if (if_y.write_enable !== 1'b0) begin errors++; $display("FAIL rnd_idle_we c=%0d got %b exp 0", c, if_y.write_enable); end
            end
            checks++; if (if_a.transaction_end !== (exp_end && owner == 0)) begin errors++; $display("FAIL rnd_end_a c=%0d got %b", c, if_a.transaction_end); end
            checks++; if (if_b.transaction_end !== (exp_end && owner == 1)) begin errors++; $display("FAIL rnd_end_b c=%0d got %b", c, if_b.transaction_end); end
            if (exp_end) begin
                checks++; if ((owner == 0 ? if_a.data_in : if_b.data_in) !== rdata) begin errors++; $display("FAIL rnd_data c=%0d exp %h", c, rdata); end
                pend[owner] = 1'b0;
                busy        = 1'b0;
                free_at     = c + 2;
            end
            checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL rnd_bus_error c=%0d got %b exp 0", c, bus_error); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        set_master(0, 32'h0, 32'h0, 1'b0, 4'h0);
        set_master(1, 32'h0, 32'h0, 1'b0, 4'h0);
        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_spurious();
`ifdef BUS_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_wait();
        test_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter for the CPU memory-bus interface (address/data_out/data_in/write_enable/write_mask/transaction_begin/transaction_end). It latches transaction requests from masters A and B and grants the shared Y port round-robin, one transaction at a time. It drives the Y-side mux select itself and routes `transaction_end` back only to the granted master. It sits between the two CPU cores and the shared memory/peripheral port.

## Interface
- `TIMEOUT_CYCLES`, default 256: WAIT-state watchdog limit; used only with `BUS_ARB_TIMEOUT_EN`; legal range ≥2.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `address_a`, `data_out_a`  in  32 each  master A request fields, held stable by A until its `transaction_end_a`.
- `write_enable_a`  in  1; `write_mask_a`  in  4  master A control.
- `transaction_begin_a`  in  1  single-cycle request pulse.
- `data_in_a`  out  32; `transaction_end_a`  out  1  response to A.
- Master B ports: same set with suffix `_b`.
- `address_y`, `data_out_y`  out  32; `write_enable_y`  out  1; `write_mask_y`  out  4  slave request fields.
- `transaction_begin_y`  out  1; `data_in_y`  in  32; `transaction_end_y`  in  1  slave handshake.
- `select`  out  1  current grant: 0 = A, 1 = B.
- `bus_error`  out  1  timeout pulse.

## Operation
- State register `pend_a`/`pend_b` is set by `transaction_begin_x`. It is cleared when the completion of that master's transaction is delivered.
- FSM states: IDLE → ISSUE → WAIT → IDLE.
- IDLE, no pending request: hold. IDLE, any pending request: load `select` with the winner and go to ISSUE.
- Arbitration: if only one master is pending, it wins. If both are pending, the master that is not `last_grant` wins. `last_grant` updates on entry to ISSUE.
- ISSUE: assert `transaction_begin_y` for exactly one cycle, then go to WAIT.
- WAIT: when `transaction_end_y` = 1, drive `transaction_end_<granted>` = 1 in the same cycle (combinational). Then clear that master's pending bit and go to IDLE.
- Y request fields: a pure mux of A or B selected by `select`. `write_enable_y` is forced to 0 in IDLE.
- `data_in_a` and `data_in_b` both carry `data_in_y`, except during timeout completion (see Configuration).
- `transaction_end` to the non-granted master is always 0.
- `transaction_end_y` outside WAIT is ignored.
- A begin pulse on a port whose pending bit is already set, or on the granted master before its completion, is ignored.
- Reset values: state IDLE, `pend_a` = `pend_b` = 0, `select` = 0, `last_grant` = B (so A wins first), `transaction_begin_y` = 0, `transaction_end_a` = `transaction_end_b` = 0, `bus_error` = 0, `write_enable_y` = 0.
- A reset asserted mid-transaction aborts it immediately. A late `transaction_end_y` after reset is ignored.

## Timing
- Begin pulse in cycle n: the pending bit is visible at n+1, `select` is valid at n+2, and `transaction_begin_y` is high in cycle n+2 only.
- A slave end in cycle m gives `transaction_end_x` in cycle m. The earliest next `transaction_begin_y` is m+2.
- A begin from the other master that arrives during WAIT is latched and served back-to-back after the return to IDLE.
- Simultaneous begins in the same cycle are resolved by `last_grant`. Both are served, in alternating order.
- The earliest legal `transaction_end_y` is the cycle after `transaction_begin_y`.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - If the count reaches `TIMEOUT_CYCLES`−1 without `transaction_end_y`: pulse `transaction_end_<granted>` and `bus_error` for one cycle, drive `data_in_<granted>` = 32'hDEAD_BEEF in that cycle, clear the pending bit, and go to IDLE.
  - A `transaction_end_y` in the same cycle as the timeout wins over the timeout: normal completion, no `bus_error`.
- Not defined: no counter; WAIT lasts until `transaction_end_y`. The `bus_error` port remains and is tied to 0.

## Structure
- Package `bus_arb_pkg`:
  - state enum (IDLE, ISSUE, WAIT);
  - grant encoding constants GRANT_A = 0, GRANT_B = 1;
  - BUS_ERR_DATA = 32'hDEAD_BEEF.
- Sub-module `rr_pick2`: combinational two-way round-robin pick from (`pend_a`, `pend_b`, `last_grant`) → winner.
- FSM, pending bits, muxes and timeout counter live in `bus_arbiter`.

## Test plan
- Reset, then a single A read (address 0x100, slave returns 0xCAFE0001 two cycles after begin_y):
  - `transaction_begin_y` pulses in cycle n+2 with `select` = 0;
  - `transaction_end_a` = 1 with `data_in_a` = 0xCAFE0001;
  - `transaction_end_b` stays 0.
- A and B begin in the same cycle right after reset: A is served first, then B is issued 2 cycles after A's end with `select` = 1, and `last_grant` = B afterwards.
- B begins during A's WAIT, and A begins again right after its completion:
  - order is A, B, A;
  - no `transaction_begin_y` is lost or duplicated.
- Spurious `transaction_end_y` in IDLE and a second `transaction_begin_a` while A is in WAIT produce no output pulses and no extra transaction.
- With `BUS_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, the slave never ends:
  - in the 8th WAIT cycle, `transaction_end_a` = 1, `data_in_a` = 0xDEADBEEF and `bus_error` = 1;
  - the FSM returns to IDLE, and a later `transaction_end_y` is ignored.
- Reset asserted during WAIT: all outputs return to reset values asynchronously, and the pending bits are clear after release.
